// File: rtl/adder_result_stage.sv
// Two-entry skid buffer capturing the adder's sum/overflow pair, plus sticky and counted overflow status.
// Optional macro ADDER_RESULT_SATURATE_EN: entries pushed with in_ovf=1 are stored saturated.
module adder_result_stage #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_f,
    input  logic             in_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    input  logic             clr,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] ovf_count
);

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] head_data_q;
    logic [WIDTH-1:0] tail_data_q;
    logic             head_ovf_q;
    logic             tail_ovf_q;
    logic             sticky_q;
    logic             sticky_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [WIDTH-1:0] store_data;
    logic             push;
    logic             pop;

    // Handshake flags come only from the registered state, so out_ready never reaches in_ready.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign out_data   = head_data_q;
    assign out_ovf    = head_ovf_q;
    assign ovf_sticky = sticky_q;
    assign ovf_count  = count_q;

    always_comb begin
        store_data = in_f;
`ifdef ADDER_RESULT_SATURATE_EN
        // A wrapped-negative sum means the true result was positive, and vice versa.
        if (in_ovf) begin
            store_data = in_f[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                       : {1'b1, {(WIDTH-1){1'b0}}};
        end
`endif
    end

    // Clear takes effect before a same-cycle overflow event.
    always_comb begin
        sticky_d = clr ? 1'b0 : sticky_q;
        count_d  = clr ? '0 : count_q;
        if (push && in_ovf) begin
            sticky_d = 1'b1;
            if (count_d != '1) begin
                count_d = count_d + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            head_data_q <= '0;
            tail_data_q <= '0;
            head_ovf_q  <= 1'b0;
            tail_ovf_q  <= 1'b0;
            sticky_q    <= 1'b0;
            count_q     <= '0;
        end else begin
            sticky_q <= sticky_d;
            count_q  <= count_d;
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        head_data_q <= store_data;
                        head_ovf_q  <= in_ovf;
                        state_q     <= ONE;
                    end
                end
                ONE: begin
                    case ({push, pop})
                        2'b10: begin
                            tail_data_q <= store_data;
                            tail_ovf_q  <= in_ovf;
                            state_q     <= FULL;
                        end
                        2'b01: state_q <= EMPTY;
                        2'b11: begin
                            head_data_q <= store_data;
                            head_ovf_q  <= in_ovf;
                        end
                        default: state_q <= ONE;
                    endcase
                end
                FULL: begin
                    if (pop) begin
                        head_data_q <= tail_data_q;
                        head_ovf_q  <= tail_ovf_q;
                        state_q     <= ONE;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_result_stage.sv
// Scoreboard bench for adder_result_stage: driver queues expected pairs, monitor checks each pop.
module tb_adder_result_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_f;
    logic        in_ovf;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_ovf;
    logic        clr;
    logic        ovf_sticky;
    logic [7:0]  ovf_count;

    adder_result_stage #(.WIDTH(16), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_f       (in_f),
        .in_ovf     (in_ovf),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ovf    (out_ovf),
        .clr        (clr),
        .ovf_sticky (ovf_sticky),
        .ovf_count  (ovf_count)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [16:0] exp_q[$];
    logic        model_sticky;
    int          model_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference for what the stage should present for an accepted pair.
    function automatic logic [15:0] exp_data(input logic [15:0] f, input logic ovf);
`ifdef ADDER_RESULT_SATURATE_EN
        if (ovf) return ($signed(f) < 0) ? 16'h7FFF : 16'h8000;
`endif
        return f;
    endfunction

    // Monitor: every pop must match the oldest outstanding expected pair.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected: got data 0x%0h ovf %0b with nothing expected", out_data, out_ovf);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                if ({out_ovf, out_data} !== e) begin
                    bad++;
                    $display("FAIL pop_data: got ovf %0b data 0x%0h expected ovf %0b data 0x%0h",
                             out_ovf, out_data, e[16], e[15:0]);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one pair (called #1 after a rising edge); force_after releases out_ready after that many stalls.
    task automatic do_push(input logic [15:0] f, input logic ovf, input logic c,
                           input int force_after, output int stalls);
        logic tmo;
        tmo = 1'b0;
        stalls = 0;
        in_valid = 1'b1;
        in_f = f;
        in_ovf = ovf;
        clr = c;
        @(negedge clk);
        while (!in_ready && !tmo) begin
            stalls++;
            if (stalls > 200) begin
                tmo = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                if (stalls >= force_after) out_ready = 1'b1;
                @(negedge clk);
            end
        end
        if (tmo) begin
            chk("push_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            clr = 1'b0;
        end else begin
            if (c) begin
                model_sticky = 1'b0;
                model_cnt = 0;
            end
            if (ovf) begin
                model_sticky = 1'b1;
                if (model_cnt < 255) model_cnt++;
            end
            exp_q.push_back({ovf, exp_data(f, ovf)});
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            clr = 1'b0;
            chk("ovf_sticky", ovf_sticky, model_sticky);
            chk("ovf_count", ovf_count, model_cnt);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
        chk("drain_out_valid", out_valid, 1'b0);
    endtask

    initial begin
        int st;
        logic c;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_f = '0;
        in_ovf = 1'b0;
        out_ready = 1'b0;
        clr = 1'b0;
        model_sticky = 1'b0;
        model_cnt = 0;
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_data", out_data, 16'h0000);
        chk("rst_out_ovf", out_ovf, 1'b0);
        chk("rst_sticky", ovf_sticky, 1'b0);
        chk("rst_count", ovf_count, 8'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single pass-through with one-cycle latency.
        out_ready = 1'b1;
        do_push(16'h1234, 1'b0, 1'b0, 1000, st);
        chk("single_valid", out_valid, 1'b1);
        chk("single_data", out_data, 16'h1234);
        @(posedge clk);
        #1;
        chk("single_gone", out_valid, 1'b0);
        chk("single_count", ovf_count, 8'd0);

        // Backpressure: third pair waits until the consumer releases.
        out_ready = 1'b0;
        do_push(16'h0001, 1'b0, 1'b0, 1000, st);
        do_push(16'h0002, 1'b0, 1'b0, 1000, st);
        chk("bp_in_ready_low", in_ready, 1'b0);
        chk("bp_head_held", out_data, 16'h0001);
        fork
            do_push(16'h0003, 1'b0, 1'b0, 1000, st);
            begin
                repeat (2) begin
                    @(negedge clk);
                    chk("bp_stall_head", out_data, 16'h0001);
                    chk("bp_stall_ready", in_ready, 1'b0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Streaming at full rate never drops in_ready.
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            do_push(16'(16'h0100 + i), 1'b0, 1'b0, 1000, st);
            chk("stream_stalls", st, 32'd0);
            chk("stream_in_ready", in_ready, 1'b1);
            chk("stream_out_valid", out_valid, 1'b1);
        end
        drain();

        // Overflow status, saturation of the counter, and clear-with-event.
        do_push(16'h8000, 1'b1, 1'b0, 1000, st);
        chk("ovf_first_sticky", ovf_sticky, 1'b1);
        chk("ovf_first_count", ovf_count, 8'd1);
        for (int i = 0; i < 300; i++) begin
            do_push(16'($urandom), 1'b1, 1'b0, 1000, st);
        end
        chk("ovf_count_sat", ovf_count, 8'hFF);
        do_push(16'h4321, 1'b1, 1'b1, 1000, st);
        chk("clr_push_count", ovf_count, 8'd1);
        chk("clr_push_sticky", ovf_sticky, 1'b1);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        model_sticky = 1'b0;
        model_cnt = 0;
        chk("clr_only_count", ovf_count, 8'd0);
        chk("clr_only_sticky", ovf_sticky, 1'b0);
        drain();

        // Saturation boundary values (expectation follows the build).
        do_push(16'h8000, 1'b1, 1'b0, 1000, st);
        chk("sat_8000", out_data, exp_data(16'h8000, 1'b1));
        do_push(16'h7FFF, 1'b1, 1'b0, 1000, st);
        chk("sat_7fff", out_data, exp_data(16'h7FFF, 1'b1));
        do_push(16'h7FFF, 1'b0, 1'b0, 1000, st);
        chk("nosat_7fff", out_data, 16'h7FFF);
        drain();

        // Randomised traffic with intermittent backpressure and clears.
        for (int i = 0; i < 200; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 15) == 0);
            do_push(16'($urandom), ($urandom_range(0, 3) == 0), c, 3, st);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        drain();

        // Asynchronous reset while FULL discards buffered entries.
        out_ready = 1'b0;
        do_push(16'hAAAA, 1'b1, 1'b0, 1000, st);
        do_push(16'h5555, 1'b0, 1'b0, 1000, st);
        chk("full_before_rst", in_ready, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_in_ready", in_ready, 1'b1);
        chk("arst_sticky", ovf_sticky, 1'b0);
        chk("arst_count", ovf_count, 8'd0);
        chk("arst_out_data", out_data, 16'h0000);
        exp_q.delete();
        model_sticky = 1'b0;
        model_cnt = 0;
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        do_push(16'hBEEF, 1'b0, 1'b0, 1000, st);
        chk("post_rst_data", out_data, 16'hBEEF);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder_result_stage.md
Name: adder_result_stage

Overview:
- Registered capture stage directly downstream of the 16-bit signed adder. Consumes the adder's sum and overflow flag through a valid/ready handshake.
- Buffers up to two results in a skid buffer, so the adder side can stream at full rate while the consumer stalls.
- Keeps a sticky overflow flag and a saturating overflow event counter for status readback.

Parameters:
- WIDTH, 16, data width of the sum path (matches the adder output).
- CNT_W, 8, width of the overflow event counter.

Ports:
- clk, input, 1, system clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, upstream sum/ovf pair is valid.
- in_ready, output, 1, stage can accept a pair this cycle.
- in_f, input, WIDTH, sum from the adder.
- in_ovf, input, 1, signed-overflow flag from the adder.
- out_valid, output, 1, head entry is valid.
- out_ready, input, 1, downstream accepts the head entry.
- out_data, output, WIDTH, head entry sum (possibly saturated, see Optional Feature).
- out_ovf, output, 1, head entry overflow flag.
- clr, input, 1, synchronous clear of the status (ovf_sticky, ovf_count) only.
- ovf_sticky, output, 1, set once any accepted pair had in_ovf=1.
- ovf_count, output, CNT_W, number of accepted pairs with in_ovf=1, saturating.

Behaviour:
- Reset (rst_n=0, asynchronous): state EMPTY, out_valid=0, in_ready=1, out_data=0, out_ovf=0, ovf_sticky=0, ovf_count=0.
  - Storage entries are cleared.
  - A reset mid-transfer discards all buffered entries.
- Handshake definitions:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_valid/in_f/in_ovf are held stable by upstream until accepted.
  - out_data/out_ovf remain stable while out_valid=1 and out_ready=0.
- FSM states, tracking occupancy:
  - EMPTY: in_ready=1, out_valid=0. push -> ONE.
  - ONE: in_ready=1, out_valid=1.
    - push & !pop -> FULL.
    - pop & !push -> EMPTY.
    - push & pop -> ONE; the new entry becomes the head next cycle.
  - FULL: in_ready=0, out_valid=1. pop -> ONE; the second entry becomes the head.
- Signal sourcing:
  - in_ready and out_valid are decoded from the registered state only; there is no combinational path from out_ready to in_ready.
- Latency and ordering:
  - Latency is 1 cycle: a pair pushed at edge N is visible at out_data with out_valid=1 after edge N when the buffer was EMPTY.
  - Order is strictly FIFO.
  - Throughput is 1 pair/cycle when out_ready is held at 1.
- Status, updated at each edge:
  - ovf_sticky: cleared by clr; set by push & in_ovf.
  - ovf_count: cleared by clr; incremented by push & in_ovf; holds at 2^CNT_W-1 with no wrap.
  - If clr and push & in_ovf occur in the same cycle, the clear applies first and then the event, giving ovf_sticky=1, ovf_count=1.
  - clr does not affect buffered data or the handshake.
- Width rules:
  - No arithmetic is performed on data; the stage stores WIDTH bits exactly.
  - out_ovf reports the in_ovf captured with that entry.

Optional Feature:
- Macro: ADDER_RESULT_SATURATE_EN.
- Defined: an entry pushed with in_ovf=1 is stored saturated.
  - in_f[WIDTH-1]=0 (wrapped positive, true result negative) stores 0x8000 (most negative).
  - in_f[WIDTH-1]=1 stores 0x7FFF (most positive).
  - out_ovf is still 1 for that entry; entries with in_ovf=0 are stored unchanged.
- Undefined: in_f is stored unchanged regardless of in_ovf.
- Status counters behave identically in both builds.

Test Plan:
- Reset, then a single push of in_f=0x1234, in_ovf=0 with out_ready=1 -> out_valid=1 and out_data=0x1234 one cycle later, then out_valid=0; ovf_count=0.
- Backpressure: hold out_ready=0 and push 0x0001, 0x0002, 0x0003 -> in_ready drops to 0 after the second push and 0x0003 is held. Release out_ready -> outputs are 0x0001, 0x0002, 0x0003 in order, with none lost or duplicated.
- Streaming: 16 consecutive pushes with out_ready=1 -> one output per cycle, state stays ONE, in_ready never deasserts.
- Overflow status: push in_f=0x8000, in_ovf=1 (from 0x4000+0x4000) -> ovf_sticky=1, ovf_count=1. Push 300 more ovf pairs -> ovf_count holds at 0xFF. Assert clr alongside another ovf push -> ovf_count=1, ovf_sticky=1.
- Saturation (ADDER_RESULT_SATURATE_EN defined):
  - push 0x8000 with ovf=1 -> out_data=0x7FFF.
  - push 0x7FFF with ovf=1 (from 0x8000+0xFFFF) -> out_data=0x8000.
  - Undefined build -> out_data is 0x8000 and 0x7FFF unchanged.
- Reset mid-operation: in state FULL, pulse rst_n low asynchronously between edges -> out_valid=0, in_ready=1, and status is zero immediately. After release, the first push is the next output, with no stale data.
